rat_ckpt: RTL and testbench

- Superscalar register alias table with branch checkpoints, sitting in the rename/issue stage between decode and the ROB/issue queue.
- Renames up to WIDTH instructions per cycle and resolves intra-group dependencies combinationally.
- Snapshots the whole mapping table into a circular checkpoint queue on branches.
- Restores the table from a snapshot in one cycle on a misprediction.

---
 rtl/rename_pkg.sv | 17 +
 rtl/rat_ckpt_if.sv | 34 +++
 rtl/rat_bypass.sv | 41 ++++
 rtl/rat_ckpt.sv | 119 +++++++++++
 tb/tb_rat_ckpt.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared sizing and types for the rename stage: register alias table entries,
// checkpoint ids and whole-table snapshots.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int ARCH_BITS = $clog2(ARCH_REGS);
    localparam int PHYS_REGS = 64;
    localparam int PR_BITS   = $clog2(PHYS_REGS);
    localparam int NUM_CKPT  = 4;
    localparam int CK_BITS   = $clog2(NUM_CKPT);

    typedef logic [ARCH_BITS-1:0] arch_reg_t;
    typedef logic [PR_BITS-1:0]   phys_tag_t;
    typedef logic [CK_BITS-1:0]   ckpt_id_t;

    // Packed so a whole table moves as one word into and out of the snapshot store.
    typedef phys_tag_t [ARCH_REGS-1:0] map_table_t;
endpackage

// File: rtl/rat_ckpt_if.sv
// Rename-group bundle between decode (master) and the alias table (slave).
interface rat_ckpt_if #(
    parameter int WIDTH = 2
);
    import rename_pkg::*;

    logic [WIDTH-1:0]           ren_valid;
    logic [WIDTH*ARCH_BITS-1:0] rs1_arch;
    logic [WIDTH*ARCH_BITS-1:0] rs2_arch;
    logic [WIDTH*ARCH_BITS-1:0] rd_arch;
    logic [WIDTH*PR_BITS-1:0]   rd_phys;
    logic [WIDTH*PR_BITS-1:0]   rs1_phys;
    logic [WIDTH*PR_BITS-1:0]   rs2_phys;
    logic [WIDTH*PR_BITS-1:0]   old_phys;
    logic                       ckpt_req;
    ckpt_id_t                   ckpt_id;
    logic                       ren_stall;
    logic                       ckpt_free;
    logic                       restore_en;
    ckpt_id_t                   restore_id;
    logic [CK_BITS:0]           ckpt_count;

    modport master (
        output ren_valid, rs1_arch, rs2_arch, rd_arch, rd_phys,
        output ckpt_req, ckpt_free, restore_en, restore_id,
        input  rs1_phys, rs2_phys, old_phys, ckpt_id, ren_stall, ckpt_count
    );

    modport slave (
        input  ren_valid, rs1_arch, rs2_arch, rd_arch, rd_phys,
        input  ckpt_req, ckpt_free, restore_en, restore_id,
        output rs1_phys, rs2_phys, old_phys, ckpt_id, ren_stall, ckpt_count
    );
endinterface

// File: rtl/rat_bypass.sv
// One rename slot's source/old-mapping lookup: table value overridden by the
// youngest older slot of the same group that writes the same register.
module rat_bypass
    import rename_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]           older_we,
    input  logic [WIDTH*ARCH_BITS-1:0] rd_arch,
    input  logic [WIDTH*PR_BITS-1:0]   rd_phys,
    input  arch_reg_t                  rs1_arch,
    input  arch_reg_t                  rs2_arch,
    input  arch_reg_t                  my_rd,
    input  logic                       my_we,
    input  phys_tag_t                  rs1_tab,
    input  phys_tag_t                  rs2_tab,
    input  phys_tag_t                  rd_tab,
    output phys_tag_t                  rs1_phys,
    output phys_tag_t                  rs2_phys,
    output phys_tag_t                  old_phys
);
    always_comb begin
        rs1_phys = rs1_tab;
        rs2_phys = rs2_tab;
        old_phys = rd_tab;
        // older_we is pre-masked to slots below this one; ascending order lets the youngest win.
        for (int j = 0; j < WIDTH; j++) begin
            if (older_we[j]) begin
                if (rd_arch[j*ARCH_BITS +: ARCH_BITS] == rs1_arch)
                    rs1_phys = rd_phys[j*PR_BITS +: PR_BITS];
                if (rd_arch[j*ARCH_BITS +: ARCH_BITS] == rs2_arch)
                    rs2_phys = rd_phys[j*PR_BITS +: PR_BITS];
                if (rd_arch[j*ARCH_BITS +: ARCH_BITS] == my_rd)
                    old_phys = rd_phys[j*PR_BITS +: PR_BITS];
            end
        end
        if (rs1_arch == '0) rs1_phys = '0;
        if (rs2_arch == '0) rs2_phys = '0;
        if (!my_we)         old_phys = '0;
    end
endmodule

// File: rtl/rat_ckpt.sv
// Superscalar register alias table with a circular queue of whole-table
// branch checkpoints and single-cycle restore on misprediction.
module rat_ckpt
    import rename_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    rat_ckpt_if.slave  bus
);
    map_table_t       table_q, table_d;
    map_table_t       snap_q [NUM_CKPT];
    ckpt_id_t         head_q, head_d;
    ckpt_id_t         tail_q, tail_d;
    logic [CK_BITS:0] count_q, count_d;

    logic [WIDTH-1:0]         we;
    logic [WIDTH*PR_BITS-1:0] rs1_flat, rs2_flat, old_flat;
    logic                     ren_stall, free_ok, restore_ok, take;
    ckpt_id_t                 head_free, restore_off;
    logic [CK_BITS:0]         count_free;

    assign ren_stall = bus.ckpt_req && (count_q == (CK_BITS+1)'(NUM_CKPT)) && !bus.ckpt_free;
    assign take      = bus.ckpt_req && (|bus.ren_valid) && !ren_stall && !bus.restore_en;

    // Free is applied before restore so the restored count is measured from the new head.
    assign free_ok     = bus.ckpt_free && (count_q != '0);
    assign head_free   = head_q + ckpt_id_t'(free_ok);
    assign count_free  = count_q - {{CK_BITS{1'b0}}, free_ok};
    assign restore_off = bus.restore_id - head_free;
    assign restore_ok  = bus.restore_en && ({1'b0, restore_off} < count_free);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slot
            assign we[gi] = bus.ren_valid[gi] && (bus.rd_arch[gi*ARCH_BITS +: ARCH_BITS] != '0)
                            && !ren_stall && !bus.restore_en;

            rat_bypass #(.WIDTH(WIDTH)) u_bypass (
                .older_we (we & WIDTH'((1 << gi) - 1)),
                .rd_arch  (bus.rd_arch),
                .rd_phys  (bus.rd_phys),
                .rs1_arch (bus.rs1_arch[gi*ARCH_BITS +: ARCH_BITS]),
                .rs2_arch (bus.rs2_arch[gi*ARCH_BITS +: ARCH_BITS]),
                .my_rd    (bus.rd_arch[gi*ARCH_BITS +: ARCH_BITS]),
                .my_we    (we[gi]),
                .rs1_tab  (table_q[bus.rs1_arch[gi*ARCH_BITS +: ARCH_BITS]]),
                .rs2_tab  (table_q[bus.rs2_arch[gi*ARCH_BITS +: ARCH_BITS]]),
                .rd_tab   (table_q[bus.rd_arch[gi*ARCH_BITS +: ARCH_BITS]]),
                .rs1_phys (rs1_flat[gi*PR_BITS +: PR_BITS]),
                .rs2_phys (rs2_flat[gi*PR_BITS +: PR_BITS]),
                .old_phys (old_flat[gi*PR_BITS +: PR_BITS])
            );
        end
    endgenerate

    assign bus.rs1_phys   = rs1_flat;
    assign bus.rs2_phys   = rs2_flat;
    assign bus.old_phys   = old_flat;
    assign bus.ren_stall  = ren_stall;
    assign bus.ckpt_id    = tail_q;
    assign bus.ckpt_count = count_q;

    always_comb begin
        table_d = table_q;
        if (restore_ok) begin
            table_d = snap_q[bus.restore_id];
        end else begin
            // Ascending slot order: the highest slot wins on a same-register collision.
            for (int k = 0; k < WIDTH; k++) begin
                if (we[k])
                    table_d[bus.rd_arch[k*ARCH_BITS +: ARCH_BITS]] = bus.rd_phys[k*PR_BITS +: PR_BITS];
            end
        end
    end

    always_comb begin
        head_d  = head_free;
        tail_d  = tail_q + ckpt_id_t'(take);
        count_d = count_free + {{CK_BITS{1'b0}}, take};
        if (restore_ok) begin
            tail_d  = bus.restore_id;
            count_d = {1'b0, restore_off};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                table_q[i] <= phys_tag_t'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            table_q <= table_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Snapshot store carries the post-group table so the branch's own writes survive a restore.
    always_ff @(posedge clk) begin
        if (take)
            snap_q[tail_q] <= table_d;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.ckpt_free)
                assert (count_q != '0);
            if (bus.restore_en)
                assert (restore_ok);
            if (bus.restore_en && free_ok)
                assert (head_q != bus.restore_id);
        end
    end
endmodule

// File: tb/tb_rat_ckpt.sv
// Vector-table bench for rat_ckpt with a scoreboard queue of expected outputs.
module tb_rat_ckpt;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rat_ckpt_if #(.WIDTH(2)) bus ();
    rat_ckpt #(.WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [1:0]      v;
        logic [1:0][4:0] r1, r2, rd;
        logic [1:0][5:0] rdp;
        logic            req, fre, rse;
        logic [1:0]      rid;
        logic [1:0][5:0] e1, e2, eo;
        logic            estall;
        logic [1:0]      eid;
        logic [2:0]      ecnt;
    } vec_t;

    typedef struct packed {
        logic [1:0][5:0] e1, e2, eo;
        logic            estall;
        logic [1:0]      eid;
        logic [2:0]      ecnt;
    } exp_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    exp_t sb [$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(int v, int a10, int a11, int b0, int b1, int d0, int d1,
                                int p0, int p1, int req, int fre, int rse, int rid,
                                int e10, int e11, int e20, int e21, int o0, int o1,
                                int st, int id, int cnt);
        vec_t t;
        t.v = 2'(v);
        t.r1[0] = 5'(a10); t.r1[1] = 5'(a11);
        t.r2[0] = 5'(b0);  t.r2[1] = 5'(b1);
        t.rd[0] = 5'(d0);  t.rd[1] = 5'(d1);
        t.rdp[0] = 6'(p0); t.rdp[1] = 6'(p1);
        t.req = 1'(req); t.fre = 1'(fre); t.rse = 1'(rse); t.rid = 2'(rid);
        t.e1[0] = 6'(e10); t.e1[1] = 6'(e11);
        t.e2[0] = 6'(e20); t.e2[1] = 6'(e21);
        t.eo[0] = 6'(o0);  t.eo[1] = 6'(o1);
        t.estall = 1'(st); t.eid = 2'(id); t.ecnt = 3'(cnt);
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        bus.ren_valid  = t.v;
        bus.rs1_arch   = t.r1;
        bus.rs2_arch   = t.r2;
        bus.rd_arch    = t.rd;
        bus.rd_phys    = t.rdp;
        bus.ckpt_req   = t.req;
        bus.ckpt_free  = t.fre;
        bus.restore_en = t.rse;
        bus.restore_id = t.rid;
    endtask

    initial begin
        //            v   rs1     rs2     rd      rdp     req fr rs id  e_rs1   e_rs2   e_old   st id cnt
        vecs[0]  = mk(0,  5, 0,   0, 9,   0, 0,   0, 0,   0, 0, 0, 0,  5, 0,   0, 9,   0, 0,   0, 0, 0);
        vecs[1]  = mk(3,  1, 3,   2, 3,   3, 3,  40,41,   0, 0, 0, 0,  1,40,   2,40,   3,40,   0, 0, 0);
        vecs[2]  = mk(1,  3, 4,   0, 5,   0, 0,   0, 0,   0, 0, 0, 0, 41, 4,   0, 5,   0, 0,   0, 0, 0);
        vecs[3]  = mk(3,  7, 7,   6, 8,   7, 7,  50,51,   0, 0, 0, 0,  7,50,   6, 8,   7,50,   0, 0, 0);
        vecs[4]  = mk(3,  7, 0,   3, 9,   0, 9,  60,61,   0, 0, 0, 0, 51, 0,  41, 9,   0, 9,   0, 0, 0);
        vecs[5]  = mk(0,  7, 9,   0, 3,   0, 0,   0, 0,   0, 0, 0, 0, 51,61,   0,41,   0, 0,   0, 0, 0);
        vecs[6]  = mk(1,  4, 3,   7, 9,   4, 0,  44, 0,   1, 0, 0, 0,  4,41,  51,61,   4, 0,   0, 0, 0);
        vecs[7]  = mk(1,  4, 0,   0, 0,   4, 0,  45, 0,   0, 0, 0, 0, 44, 0,   0, 0,  44, 0,   0, 1, 1);
        vecs[8]  = mk(3,  4, 4,   3, 7,   4, 4,  46,47,   0, 0, 1, 0, 45,45,  41,51,   0, 0,   0, 1, 1);
        vecs[9]  = mk(0,  4, 7,   3, 9,   0, 0,   0, 0,   0, 0, 0, 0, 44,51,  41,61,   0, 0,   0, 0, 0);
        vecs[10] = mk(1, 10, 0,   0, 0,  10, 0,  20, 0,   1, 0, 0, 0, 10, 0,   0, 0,  10, 0,   0, 0, 0);
        vecs[11] = mk(1, 10, 0,   0, 0,  11, 0,  21, 0,   1, 0, 0, 0, 20, 0,   0, 0,  11, 0,   0, 1, 1);
        vecs[12] = mk(1, 11, 0,   0, 0,  12, 0,  22, 0,   1, 0, 0, 0, 21, 0,   0, 0,  12, 0,   0, 2, 2);
        vecs[13] = mk(1, 12, 0,   0, 0,  13, 0,  23, 0,   1, 0, 0, 0, 22, 0,   0, 0,  13, 0,   0, 3, 3);
        vecs[14] = mk(1, 13, 0,   0, 0,  14, 0,  24, 0,   1, 0, 0, 0, 23, 0,   0, 0,   0, 0,   1, 0, 4);
        vecs[15] = mk(0, 14,13,   0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 14,23,   0, 0,   0, 0,   0, 0, 4);
        vecs[16] = mk(1, 14, 0,   0, 0,  14, 0,  24, 0,   1, 1, 0, 0, 14, 0,   0, 0,  14, 0,   0, 0, 4);
        vecs[17] = mk(0, 14,10,   0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 24,20,   0, 0,   0, 0,   0, 1, 4);
        vecs[18] = mk(0, 13,14,   0, 0,   0, 0,   0, 0,   0, 1, 1, 3, 23,24,   0, 0,   0, 0,   0, 1, 4);
        vecs[19] = mk(0, 13,14,  12,11,   0, 0,   0, 0,   0, 0, 0, 0, 23,14,  22,21,   0, 0,   0, 3, 1);
        vecs[20] = mk(0,  0, 0,   0, 0,   0, 0,   0, 0,   0, 1, 0, 0,  0, 0,   0, 0,   0, 0,   0, 3, 1);
        vecs[21] = mk(0,  4, 3,   0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 44,41,   0, 0,   0, 0,   0, 3, 0);

        drive(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(negedge clk);
            drive(vecs[i]);
            e.e1 = vecs[i].e1; e.e2 = vecs[i].e2; e.eo = vecs[i].eo;
            e.estall = vecs[i].estall; e.eid = vecs[i].eid; e.ecnt = vecs[i].ecnt;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rs1_phys[%0d]", k), i, 32'(bus.rs1_phys[k*6 +: 6]), 32'(e.e1[k]));
                chk($sformatf("rs2_phys[%0d]", k), i, 32'(bus.rs2_phys[k*6 +: 6]), 32'(e.e2[k]));
                chk($sformatf("old_phys[%0d]", k), i, 32'(bus.old_phys[k*6 +: 6]), 32'(e.eo[k]));
            end
            chk("ren_stall", i, 32'(bus.ren_stall), 32'(e.estall));
            chk("ckpt_id", i, 32'(bus.ckpt_id), 32'(e.eid));
            chk("ckpt_count", i, 32'(bus.ckpt_count), 32'(e.ecnt));
            $display("vec %0d valid=%b rs1=%0d,%0d rs2=%0d,%0d old=%0d,%0d stall=%0d id=%0d cnt=%0d",
                     i, bus.ren_valid, bus.rs1_phys[5:0], bus.rs1_phys[11:6],
                     bus.rs2_phys[5:0], bus.rs2_phys[11:6], bus.old_phys[5:0], bus.old_phys[11:6],
                     bus.ren_stall, bus.ckpt_id, bus.ckpt_count);
        end
        chk("scoreboard_empty", NV, 32'(sb.size()), 32'd0);

        // Mid-cycle reset must restore the identity map without waiting for a clock edge.
        @(negedge clk);
        drive(mk(0, 4,13, 0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        #1;
        chk("pre_reset_rs1[0]", 100, 32'(bus.rs1_phys[5:0]), 32'd44);
        chk("pre_reset_rs1[1]", 100, 32'(bus.rs1_phys[11:6]), 32'd23);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_rs1[0]", 101, 32'(bus.rs1_phys[5:0]), 32'd4);
        chk("async_reset_rs1[1]", 101, 32'(bus.rs1_phys[11:6]), 32'd13);
        chk("async_reset_id", 101, 32'(bus.ckpt_id), 32'd0);
        chk("async_reset_count", 101, 32'(bus.ckpt_count), 32'd0);
        $display("async reset rs1=%0d,%0d id=%0d cnt=%0d",
                 bus.rs1_phys[5:0], bus.rs1_phys[11:6], bus.ckpt_id, bus.ckpt_count);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
